// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   XLEN, ADDR_MASK_LSB  - datapath width and word-alignment shift
//   F3_*                 - RV32I funct3 size/sign codes
//   state_t              - controller FSM encoding
package lsu_pkg;

  localparam int XLEN          = 32;
  localparam int ADDR_MASK_LSB = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEM_RD  = 3'd1,
    MEM_RSP = 3'd2,
    MEM_WR  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle between the MEM stage / data memory and the load/store unit.
// Pipeline side: i_req, i_we, i_funct3, i_addr, i_wdata in; o_busy, o_done,
//                o_rdata, o_err out.
// Memory side:   o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren out; i_mem_rd in.
// master = environment (pipeline + memory), slave = load/store unit.
interface lsu_mem_ctrl_if #(
  parameter int XLEN = lsu_pkg::XLEN
);

  logic            i_req;
  logic            i_we;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_wdata;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_rdata;
  logic            o_err;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wd;
  logic            o_mem_wen;
  logic            o_mem_ren;
  logic [XLEN-1:0] i_mem_rd;

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rd,
    input  o_busy, o_done, o_rdata, o_err,
           o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rd,
    output o_busy, o_done, o_rdata, o_err,
           o_mem_addr, o_mem_wd, o_mem_wen, o_mem_ren
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Inputs:  funct3, we, addr (byte address), wdata (right-aligned store data),
//          mem_rd (word read from memory)
// Outputs: load_data (extracted + extended load value),
//          merged (memory word with store lanes replaced),
//          err (illegal funct3 or misaligned address)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_rd,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged,
  output logic            err
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Stores only know B/H/W, so the unsigned codes are illegal with we=1.
  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr[0];
      F3_W:    err = addr[1] | addr[0];
      F3_BU:   err = we;
      F3_HU:   err = we | addr[0];
      default: err = 1'b1;
    endcase
  end

  // Little-endian lane pick: byte k sits at bits [8k+7:8k].
  always_comb begin
    byte_lane = mem_rd[7:0];
    case (addr[1:0])
      2'd0: byte_lane = mem_rd[7:0];
      2'd1: byte_lane = mem_rd[15:8];
      2'd2: byte_lane = mem_rd[23:16];
      2'd3: byte_lane = mem_rd[31:24];
      default: byte_lane = mem_rd[7:0];
    endcase
    half_lane = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
  end

  always_comb begin
    load_data = mem_rd;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_H:    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_lane};
      default: load_data = mem_rd;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    case (funct3)
      F3_B: begin
        case (addr[1:0])
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged[7:0] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Ports: i_clk, i_rst_n (synchronous, active low) plus the bus interface
//   (slave modport) carrying the pipeline request/response and the data
//   memory address/write/enable signals. Sub-word stores are done as a
//   read-modify-write because the memory only has a word write enable.
module lsu_mem_ctrl #(
  parameter int XLEN          = lsu_pkg::XLEN,
  parameter int ADDR_MASK_LSB = lsu_pkg::ADDR_MASK_LSB
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lsu_mem_ctrl_if.slave        bus
);

  import lsu_pkg::*;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, merged_q, rdata_q;
  logic [2:0]      funct3_q;
  logic            we_q, err_q;
  logic            accept;

  logic [2:0]      sel_funct3;
  logic            sel_we;
  logic [XLEN-1:0] sel_addr, sel_wdata;
  logic [XLEN-1:0] load_data, merged;
  logic            chk_err;
  logic [XLEN-1:0] aligned_addr;

  // In IDLE the lane logic classifies the incoming request; afterwards it
  // works on the latched copy so the pipeline may change its inputs.
  assign sel_funct3 = (state_q == IDLE) ? bus.i_funct3 : funct3_q;
  assign sel_we     = (state_q == IDLE) ? bus.i_we     : we_q;
  assign sel_addr   = (state_q == IDLE) ? bus.i_addr   : addr_q;
  assign sel_wdata  = (state_q == IDLE) ? bus.i_wdata  : wdata_q;

  lsu_align u_align (
    .funct3    (sel_funct3),
    .we        (sel_we),
    .addr      (sel_addr),
    .wdata     (sel_wdata),
    .mem_rd    (bus.i_mem_rd),
    .load_data (load_data),
    .merged    (merged),
    .err       (chk_err)
  );

  assign aligned_addr = {addr_q[XLEN-1:ADDR_MASK_LSB], {ADDR_MASK_LSB{1'b0}}};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          accept = 1'b1;
          if (chk_err)                     state_d = DONE;
          else if (!bus.i_we)              state_d = MEM_RD;
          else if (bus.i_funct3 == F3_W)   state_d = MEM_WR;
          else                             state_d = MEM_RD;
        end
      end
      MEM_RD:  state_d = MEM_RSP;
      MEM_RSP: state_d = we_q ? MEM_WR : DONE;
      MEM_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rdata is cleared when a store or error is accepted so those
  // completions report zero; loads overwrite it in MEM_RSP.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.i_addr;
        wdata_q  <= bus.i_wdata;
        funct3_q <= bus.i_funct3;
        we_q     <= bus.i_we;
        err_q    <= chk_err;
        merged_q <= (bus.i_we && !chk_err) ? merged : '0;
        if (chk_err || bus.i_we) rdata_q <= '0;
      end
      if (state_q == MEM_RSP) begin
        if (we_q) merged_q <= merged;
        else      rdata_q  <= load_data;
      end
    end
  end

  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_err      = (state_q == DONE) && err_q;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_mem_ren  = (state_q == MEM_RD);
  assign bus.o_mem_wen  = (state_q == MEM_WR);
  assign bus.o_mem_addr = (state_q == MEM_RD || state_q == MEM_WR) ? aligned_addr : '0;
  assign bus.o_mem_wd   = (state_q == MEM_WR) ? merged_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a behavioural synchronous-read
// memory, a reference model producing expected results into a scoreboard
// queue, and a collector that pops and compares on each completion.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_mem = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.XLEN(32)) bus ();

  lsu_mem_ctrl #(.XLEN(32), .ADDR_MASK_LSB(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] err;
    int          done_cyc;
    int          ren_cyc;
    int          wen_cyc;
    logic [31:0] wd;
    logic [31:0] maddr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          wen_total = 0;

  function automatic logic [31:0] initWord(input int idx);
    if (idx == 8'h40) return 32'h8070F0A5;
    return 32'h1357_9BDF ^ (32'(idx) * 32'h0101_0101);
  endfunction

  // Synchronous-read data memory: read data appears the cycle after ren.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
    end else begin
      if (bus.o_mem_ren) bus.i_mem_rd <= mem[bus.o_mem_addr[9:2]];
      if (bus.o_mem_wen) mem[bus.o_mem_addr[9:2]] <= bus.o_mem_wd;
    end
  end

  always @(negedge clk) if (bus.o_mem_wen) wen_total++;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: computes the expected outcome, pushes it to the
  // scoreboard and updates the reference memory, then drives the request.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] word, lane, mask;
    int          sh, size;
    logic        legal;
    word  = ref_mem[addr[9:2]];
    sh    = 8 * int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.rdata = 0; e.err = 0; e.ren_cyc = -1; e.wen_cyc = -1; e.wd = 0;
    e.maddr = {addr[31:2], 2'b00};
    if (!legal || ((int'(addr[1:0]) % size) != 0)) begin
      e.err = 1; e.done_cyc = 1;
    end else if (!we) begin
      lane = word >> sh;
      case (f3)
        3'd0: e.rdata = 32'($signed(lane[7:0]));
        3'd4: e.rdata = {24'd0, lane[7:0]};
        3'd1: e.rdata = 32'($signed(lane[15:0]));
        3'd5: e.rdata = {16'd0, lane[15:0]};
        default: e.rdata = word;
      endcase
      e.ren_cyc = 1; e.done_cyc = 3;
    end else if (f3 == 3'd2) begin
      e.wen_cyc = 1; e.done_cyc = 2; e.wd = wdata;
      ref_mem[addr[9:2]] = wdata;
    end else begin
      mask = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      e.wd = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      e.ren_cyc = 1; e.wen_cyc = 3; e.done_cyc = 4;
      ref_mem[addr[9:2]] = e.wd;
    end
    sb_q.push_back(e);
    @(negedge clk);
    bus.i_req    = 1'b1;
    bus.i_we     = we;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wdata;
  endtask

  // Watches one transaction (bounded), then pops and compares.
  task automatic collectResponse(input string name, input logic hold);
    exp_t        e;
    int          ren_n = 0, wen_n = 0, ren_c = -1, wen_c = -1, done_c = -1;
    logic [31:0] raddr = 0, waddr = 0, wd = 0, rdata = 0, err = 0;
    @(posedge clk);
    #1;
    if (!hold) bus.i_req = 1'b0;
    for (int k = 1; k <= 10 && done_c < 0; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput({name, "_busy"}, 32'(bus.o_busy), 32'd1);
      if (bus.o_mem_ren) begin ren_n++; ren_c = k; raddr = bus.o_mem_addr; end
      if (bus.o_mem_wen) begin wen_n++; wen_c = k; waddr = bus.o_mem_addr; wd = bus.o_mem_wd; end
      if (bus.o_done) begin done_c = k; rdata = bus.o_rdata; err = 32'(bus.o_err); end
    end
    bus.i_req = 1'b0;
    e = sb_q.pop_front();
    checkOutput({name, "_done_cycle"}, 32'(done_c), 32'(e.done_cyc));
    checkOutput({name, "_err"},        err,           e.err);
    checkOutput({name, "_rdata"},      rdata,         e.rdata);
    checkOutput({name, "_ren_count"},  32'(ren_n),    (e.ren_cyc >= 0) ? 32'd1 : 32'd0);
    checkOutput({name, "_ren_cycle"},  32'(ren_c),    32'(e.ren_cyc));
    checkOutput({name, "_wen_count"},  32'(wen_n),    (e.wen_cyc >= 0) ? 32'd1 : 32'd0);
    checkOutput({name, "_wen_cycle"},  32'(wen_c),    32'(e.wen_cyc));
    if (e.ren_cyc >= 0) checkOutput({name, "_ren_addr"}, raddr, e.maddr);
    if (e.wen_cyc >= 0) begin
      checkOutput({name, "_wen_addr"}, waddr, e.maddr);
      checkOutput({name, "_wen_wd"},   wd,    e.wd);
    end
    @(negedge clk);
    checkOutput({name, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
    checkOutput({name, "_idle_ren"},  32'(bus.o_mem_ren | bus.o_mem_wen), 32'd0);
  endtask

  task automatic runTxn(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic hold);
    applyStimulus(we, f3, addr, wdata);
    collectResponse(name, hold);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_busy"},  32'(bus.o_busy),    32'd0);
    checkOutput({name, "_done"},  32'(bus.o_done),    32'd0);
    checkOutput({name, "_err"},   32'(bus.o_err),     32'd0);
    checkOutput({name, "_ren"},   32'(bus.o_mem_ren), 32'd0);
    checkOutput({name, "_wen"},   32'(bus.o_mem_wen), 32'd0);
    checkOutput({name, "_maddr"}, bus.o_mem_addr,     32'd0);
    checkOutput({name, "_wd"},    bus.o_mem_wd,       32'd0);
    checkOutput({name, "_rdata"}, bus.o_rdata,        32'd0);
  endtask

  initial begin
    int wen_before;
    bus.i_req = 0; bus.i_we = 0; bus.i_funct3 = 0; bus.i_addr = 0; bus.i_wdata = 0;
    bus.i_mem_rd = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
    load_mem = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    runTxn("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 1'b0);
    runTxn("lbu_101", 1'b0, 3'b100, 32'h101, 32'h0, 1'b0);
    runTxn("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
    runTxn("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 1'b0);
    runTxn("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
    runTxn("sb_103",  1'b1, 3'b000, 32'h103, 32'h12345678, 1'b0);
    runTxn("sw_104",  1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b1);
    runTxn("lw_102_mis",   1'b0, 3'b010, 32'h102, 32'h0, 1'b0);
    runTxn("sh_101_mis",   1'b1, 3'b001, 32'h101, 32'hFFFF, 1'b0);
    runTxn("ld_f3_011",    1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
    runTxn("sbu_illegal",  1'b1, 3'b100, 32'h100, 32'h55, 1'b0);
    runTxn("sh_106",  1'b1, 3'b001, 32'h106, 32'h0000BEEF, 1'b0);
    runTxn("lh_106",  1'b0, 3'b001, 32'h106, 32'h0, 1'b0);
    runTxn("lb_100",  1'b0, 3'b000, 32'h100, 32'h0, 1'b0);

    // Abort an SH while it waits for read data.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_funct3 = 3'b001;
    bus.i_addr = 32'h102; bus.i_wdata = 32'hAAAA5555;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_abort_ren", 32'(bus.o_mem_ren), 32'd1);
    @(negedge clk);
    wen_before = wen_total;
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("rst_abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_abort_no_wen", 32'(wen_total), 32'(wen_before));

    runTxn("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0);

    checkOutput("mem_word_100", mem[8'h40], ref_mem[8'h40]);
    checkOutput("mem_word_104", mem[8'h41], ref_mem[8'h41]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
